// File: rtl/gray_code_counter_if.sv
// Control and count bus of the Gray-code counter.
// The master drives the controls and the slave (the counter) drives the counts.
interface gray_code_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic             load_is_gray;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;

    modport master (
        output en, dir, load, load_is_gray, load_val,
        input  bin_out, gray_out, wrap
    );

    modport slave (
        input  en, dir, load, load_is_gray, load_val,
        output bin_out, gray_out, wrap
    );
endinterface

// File: rtl/gray_code_counter.sv
// Registered up/down counter with binary and Gray outputs, parallel load and wrap strobe.
// Gray is encoded from the next binary value, so one gray bit changes per count step.
module gray_code_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    gray_code_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it
    always_comb begin
        load_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(bus.load_val >> i);
        end
    end

    // Next count: load beats enable, enable beats hold
    always_comb begin
        next_bin  = bin_q;
        next_wrap = 1'b0;
        if (bus.load) begin
            next_bin = bus.load_is_gray ? load_bin : bus.load_val;
        end else if (bus.en) begin
            if (bus.dir) begin
                next_bin  = bin_q + WIDTH'(1);
                next_wrap = &bin_q;
            end else begin
                next_bin  = bin_q - WIDTH'(1);
                next_wrap = ~|bin_q;
            end
        end
        next_gray = next_bin ^ (next_bin >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= next_gray;
            wrap_q <= next_wrap;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: a 4-bit instance at reset 0 and an 8-bit instance at reset 200.
module tb_gray_code_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gray_code_counter_if #(.WIDTH(4)) a_if ();
    gray_code_counter_if #(.WIDTH(8)) b_if ();

    gray_code_counter #(.WIDTH(4), .RESET_VAL(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    gray_code_counter #(.WIDTH(8), .RESET_VAL(200)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    // Hand-written 4-bit Gray table, indexed by the binary count
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
        check({tag, "_bin"},  32'(a_if.bin_out),  32'(b));
        check({tag, "_gray"}, 32'(a_if.gray_out), 32'(g));
        check({tag, "_wrap"}, 32'(a_if.wrap),     32'(w));
    endtask

    initial begin
        logic [3:0] prev_a;
        logic [7:0] prev_b;
        logic [7:0] exp_b;

        a_if.en = 1'b0; a_if.dir = 1'b1; a_if.load = 1'b0; a_if.load_is_gray = 1'b0; a_if.load_val = 4'h0;
        b_if.en = 1'b0; b_if.dir = 1'b1; b_if.load = 1'b0; b_if.load_is_gray = 1'b0; b_if.load_val = 8'h00;

        // Asynchronous reset, checked before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        check_a("rst_a", 4'h0, 4'h0, 1'b0);
        check("rst_b_bin",  32'(b_if.bin_out),  32'd200);
        check("rst_b_gray", 32'(b_if.gray_out), 32'hAC);
        check("rst_b_wrap", 32'(b_if.wrap),     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_if.en = 1'b1; a_if.dir = 1'b1;
        #1;
        check_a("rst_rel", 4'h0, 4'h0, 1'b0);

        // Up sweep through the wrap
        prev_a = a_if.gray_out;
        for (int k = 1; k <= 17; k++) begin
            step();
            check_a($sformatf("up%0d", k), 4'(k % 16), gtab[k % 16], (k == 16));
            check($sformatf("up%0d_onebit", k), 32'($countones(a_if.gray_out ^ prev_a)), 32'd1);
            prev_a = a_if.gray_out;
        end
        check_a("up_spot15_prev", 4'h1, 4'b0001, 1'b0);

        // Hold
        a_if.en = 1'b0;
        step();
        check_a("hold", 4'h1, 4'b0001, 1'b0);

        // Down wrap
        a_if.load = 1'b1; a_if.load_is_gray = 1'b0; a_if.load_val = 4'b0001;
        step();
        check_a("dn_load", 4'h1, 4'b0001, 1'b0);
        a_if.load = 1'b0; a_if.en = 1'b1; a_if.dir = 1'b0;
        step();
        check_a("dn0", 4'h0, 4'b0000, 1'b0);
        step();
        check_a("dn_wrap", 4'hF, 4'b1000, 1'b1);
        a_if.en = 1'b0;
        step();
        check_a("dn_hold", 4'hF, 4'b1000, 1'b0);

        // Gray load with en/dir active, which must be ignored
        a_if.load = 1'b1; a_if.load_is_gray = 1'b1; a_if.load_val = 4'b1101; a_if.en = 1'b1; a_if.dir = 1'b0;
        step();
        check_a("gload", 4'b1001, 4'b1101, 1'b0);

        // Binary load wins over enable
        a_if.load_is_gray = 1'b0; a_if.load_val = 4'b0011; a_if.dir = 1'b1;
        step();
        check_a("lprio", 4'b0011, 4'b0010, 1'b0);

        // Direction change takes effect on the next step
        a_if.load = 1'b0;
        step();
        check_a("dir_up", 4'h4, 4'b0110, 1'b0);
        a_if.dir = 1'b0;
        step();
        check_a("dir_dn", 4'h3, 4'b0010, 1'b0);
        a_if.dir = 1'b1;
        step();
        check_a("dir_up2", 4'h4, 4'b0110, 1'b0);

        // Load of all-ones then count up: wrap with no load in the way
        a_if.load = 1'b1; a_if.load_val = 4'hF;
        step();
        check_a("lF", 4'hF, 4'b1000, 1'b0);
        a_if.load = 1'b0;
        step();
        check_a("lF_wrap", 4'h0, 4'b0000, 1'b1);

        // Async reset mid-count at 1010
        a_if.load = 1'b1; a_if.load_val = 4'b1010;
        step();
        check_a("mid_load", 4'b1010, 4'b1111, 1'b0);
        a_if.load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_a("mid_rst", 4'h0, 4'h0, 1'b0);
        check("mid_rst_b", 32'(b_if.bin_out), 32'd200);
        #3 rst_n = 1'b1;
        step();
        check_a("resume", 4'h1, 4'b0001, 1'b0);
        a_if.en = 1'b0;

        // 8-bit sweep from 200 through 255 -> 0
        b_if.en = 1'b1; b_if.dir = 1'b1;
        prev_b = b_if.gray_out;
        for (int k = 1; k <= 57; k++) begin
            step();
            exp_b = 8'(200 + k);
            check($sformatf("b%0d_bin", k),  32'(b_if.bin_out), 32'(exp_b));
            check($sformatf("b%0d_wrap", k), 32'(b_if.wrap),    32'(k == 56));
            check($sformatf("b%0d_onebit", k), 32'($countones(b_if.gray_out ^ prev_b)), 32'd1);
            if (k == 55) check("b255_gray", 32'(b_if.gray_out), 32'h80);
            if (k == 56) check("b0_gray",   32'(b_if.gray_out), 32'h00);
            prev_b = b_if.gray_out;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
